// File: rtl/seven_seg_pkg.sv
// Shared constants and decode helpers for the 7-segment scan driver.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
//
// Contents:
//   SEG_BLANK     - all segments off, in {g,f,e,d,c,b,a} order, active-high
//   SEG_DASH      - middle bar only (segment g); shown for out-of-range BCD codes
//   SEG_HEX_TABLE - glyphs for codes 0..F; entry N sits at bits [7N+6:7N]
//   seg_pix_t     - one displayed digit: segment pattern plus decimal point
//   seg_decode()  - (code, hex_mode) -> 7-bit glyph, before any blanking
package seven_seg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_DASH  = 7'h40;

    // Listed from F down to 0 so that SEG_HEX_TABLE[code] selects the glyph.
    localparam logic [15:0][6:0] SEG_HEX_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39,   // F E d C
        7'h7C, 7'h77, 7'h6F, 7'h7F,   // b A 9 8
        7'h07, 7'h7D, 7'h6D, 7'h66,   // 7 6 5 4
        7'h4F, 7'h5B, 7'h06, 7'h3F    // 3 2 1 0
    };

    typedef struct packed {
        logic [6:0] seg;
        logic       dp;
    } seg_pix_t;

    // In BCD mode, codes 10..15 are not legal digits; they show a dash so a
    // broken upstream converter is visible on the board instead of looking
    // like a valid hex letter.
    function automatic logic [6:0] seg_decode(input logic [3:0] code,
                                              input logic       hex_mode);
        logic [6:0] glyph;
        glyph = SEG_HEX_TABLE[code];
        if (!hex_mode && (code > 4'd9)) begin
            glyph = SEG_DASH;
        end
        return glyph;
    endfunction

endpackage

// File: rtl/seg_code_decoder.sv
// Converts one 4-bit digit code into its 7-segment glyph, with blanking.
// Latency: combinational (0 cycles); the caller registers the result.
// Backpressure: none.
//
// Ports:
//   code     in  4  digit code to display
//   hex_mode in  1  1 = hex glyphs for 0..F; 0 = BCD, codes 10..15 show a dash
//   blank    in  1  1 = force all segments off (leading-zero suppression)
//   seg      out 7  {g,f,e,d,c,b,a}, active-high
module seg_code_decoder
    import seven_seg_pkg::*;
(
    input  logic [3:0] code,
    input  logic       hex_mode,
    input  logic       blank,
    output logic [6:0] seg
);

    // Blanking overrides the decode, including the BCD error dash: a blanked
    // position is by construction a zero, so there is never a dash to hide.
    always_comb begin
        seg = seg_decode(code, hex_mode);
        if (blank) begin
            seg = SEG_BLANK;
        end
    end

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed N-digit 7-segment driver with frame-aligned (tear-free) updates.
// Latency: outputs are registered one cycle after the scan index/slot counter.
// Backpressure: none; load is a single-cycle strobe and is always accepted.
//
// Ports:
//   clk        in  1             clock
//   reset      in  1             asynchronous, active-high reset
//   enable     in  1             1 = scan running; 0 = counters frozen, display dark
//   load       in  1             strobe: capture digits_in/dp_in into the pending buffer
//   digits_in  in  4*NUM_DIGITS  digit codes, [3:0] = digit 0 (least significant)
//   dp_in      in  NUM_DIGITS    decimal point per digit
//   hex_mode   in  1             1 = hex glyphs; 0 = BCD (10..15 show a dash)
//   blank_lz   in  1             1 = suppress leading zeros (digit 0 always shown)
//   seg_out    out 7             {g,f,e,d,c,b,a}, registered
//   dp_out     out 1             decimal point of the active digit, registered
//   digit_sel  out NUM_DIGITS    one-hot active digit, registered
//   frame_done out 1             one-cycle pulse after the last digit's slot ends
//
// Build option: define SEVEN_SEG_GHOST_BLANK_EN to hold digit_sel inactive for
// the first two cycles of every slot (anti-ghosting dead time). Segments still
// switch on slot entry and frame_done timing is the same in both builds.
module seven_seg_scan_driver
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 1000,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int SEL_ACTIVE_LOW = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      load,
    input  logic [4*NUM_DIGITS-1:0]   digits_in,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    input  logic                      hex_mode,
    input  logic                      blank_lz,
    output logic [6:0]                seg_out,
    output logic                      dp_out,
    output logic [NUM_DIGITS-1:0]     digit_sel,
    output logic                      frame_done
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int CNT_W = $clog2(REFRESH_DIV);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    // Pin levels meaning "off". They double as XOR masks: an active-high
    // internal value XORed with the off pattern gives the pin-level value.
    localparam logic [6:0]            SEG_OFF = {7{SEG_ACTIVE_LOW != 0}};
    localparam logic                  DP_OFF  = (SEG_ACTIVE_LOW != 0);
    localparam logic [NUM_DIGITS-1:0] SEL_OFF = {NUM_DIGITS{SEL_ACTIVE_LOW != 0}};

    // ------------------------------------------------------------------
    // Scan state
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] slot_cnt;
    logic [IDX_W-1:0] scan_idx;
    logic             slot_end;
    logic             frame_end;

    assign slot_end  = enable && (slot_cnt == CNT_LAST);
    assign frame_end = slot_end && (scan_idx == IDX_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_cnt <= '0;
            scan_idx <= '0;
        end else if (enable) begin
            if (slot_end) begin
                slot_cnt <= '0;
                scan_idx <= (scan_idx == IDX_LAST) ? '0 : scan_idx + 1'b1;
            end else begin
                slot_cnt <= slot_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Pending / committed digit buffers
    // ------------------------------------------------------------------
    // The committed copy is what the scan reads. It is written only on the
    // edge that ends the last digit's slot, so every frame shows one
    // consistent value even when the datapath updates mid-frame.
    logic [NUM_DIGITS-1:0][3:0] pend_digits;
    logic [NUM_DIGITS-1:0]      pend_dp;
    logic                       pend_vld;
    logic [NUM_DIGITS-1:0][3:0] cm_digits;
    logic [NUM_DIGITS-1:0]      cm_dp;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_digits <= '0;
            pend_dp     <= '0;
            pend_vld    <= 1'b0;
            cm_digits   <= '0;
            cm_dp       <= '0;
        end else if (frame_end && load) begin
            // The fresh inputs are newer than anything pending, so they go
            // straight to the display and any older pending data is dropped.
            cm_digits <= digits_in;
            cm_dp     <= dp_in;
            pend_vld  <= 1'b0;
        end else if (frame_end && pend_vld) begin
            cm_digits <= pend_digits;
            cm_dp     <= pend_dp;
            pend_vld  <= 1'b0;
        end else if (load) begin
            // A second load before commit simply overwrites the buffer.
            pend_digits <= digits_in;
            pend_dp     <= dp_in;
            pend_vld    <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Leading-zero mask
    // ------------------------------------------------------------------
    // Walk down from the most significant digit; the run of blanked digits
    // ends at the first non-zero code. Digit 0 is never in the mask so a
    // value of zero still shows a single "0".
    logic [NUM_DIGITS-1:0] lz_mask;
    logic                  lz_run;

    always_comb begin
        lz_mask = '0;
        lz_run  = blank_lz;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            lz_run     = lz_run && (cm_digits[i] == 4'd0);
            lz_mask[i] = lz_run;
        end
    end

    // ------------------------------------------------------------------
    // Active digit decode
    // ------------------------------------------------------------------
    seg_pix_t cur_pix;
    logic [6:0] cur_seg;

    seg_code_decoder u_decoder (
        .code     (cm_digits[scan_idx]),
        .hex_mode (hex_mode),
        .blank    (lz_mask[scan_idx]),
        .seg      (cur_seg)
    );

    // The decimal point ignores blanking: a blanked zero can still carry a
    // separator dot, e.g. " .5".
    always_comb begin
        cur_pix.seg = cur_seg;
        cur_pix.dp  = cm_dp[scan_idx];
    end

    // One-hot select for the digit currently being scanned.
    logic [NUM_DIGITS-1:0] sel_nxt;

    always_comb begin
        sel_nxt = '0;
        if (enable) begin
            sel_nxt[scan_idx] = 1'b1;
        end
`ifdef SEVEN_SEG_GHOST_BLANK_EN
        // Keep the digit dark while the segment lines settle on the new
        // glyph, so the previous digit's pattern never flashes on this one.
        if (slot_cnt < CNT_W'(2)) begin
            sel_nxt = '0;
        end
`else
`endif
    end

    // ------------------------------------------------------------------
    // Output registers (polarity applied here, nowhere else)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seg_out    <= SEG_OFF;
            dp_out     <= DP_OFF;
            digit_sel  <= SEL_OFF;
            frame_done <= 1'b0;
        end else begin
            if (enable) begin
                seg_out <= cur_pix.seg ^ SEG_OFF;
                dp_out  <= cur_pix.dp ^ DP_OFF;
            end else begin
                seg_out <= SEG_OFF;
                dp_out  <= DP_OFF;
            end
            digit_sel  <= sel_nxt ^ SEL_OFF;
            frame_done <= frame_end;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Self-checking bench for seven_seg_scan_driver (NUM_DIGITS=4, REFRESH_DIV=4).
// Stimulus pushes the expected glyph of every upcoming slot into a queue; a
// monitor pops one entry each time a new digit becomes active and compares.
module tb_seven_seg_scan_driver;

    localparam int ND  = 4;
    localparam int DIV = 4;

    logic          clk;
    logic          reset;
    logic          enable;
    logic          load;
    logic [4*ND-1:0] digits_in;
    logic [ND-1:0] dp_in;
    logic          hex_mode;
    logic          blank_lz;
    logic [6:0]    seg_out;
    logic          dp_out;
    logic [ND-1:0] digit_sel;
    logic          frame_done;

    seven_seg_scan_driver #(
        .NUM_DIGITS     (ND),
        .REFRESH_DIV    (DIV),
        .SEG_ACTIVE_LOW (0),
        .SEL_ACTIVE_LOW (0)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .load       (load),
        .digits_in  (digits_in),
        .dp_in      (dp_in),
        .hex_mode   (hex_mode),
        .blank_lz   (blank_lz),
        .seg_out    (seg_out),
        .dp_out     (dp_out),
        .digit_sel  (digit_sel),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [ND-1:0] sel;
        logic [6:0]    seg;
        logic          dp;
    } slot_exp_t;

    slot_exp_t exp_q[$];

    int checks   = 0;
    int failures = 0;
    bit gap_chk  = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic push_slot(input int idx, input logic [6:0] seg, input logic dp);
        slot_exp_t e;
        e.sel = ND'(1) << idx;
        e.seg = seg;
        e.dp  = dp;
        exp_q.push_back(e);
    endtask

    // Glyphs given digit 0 first; dp bit i belongs to digit i.
    task automatic push_frame(input logic [6:0] s0, input logic [6:0] s1,
                              input logic [6:0] s2, input logic [6:0] s3,
                              input logic [3:0] dp);
        push_slot(0, s0, dp[0]);
        push_slot(1, s1, dp[1]);
        push_slot(2, s2, dp[2]);
        push_slot(3, s3, dp[3]);
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] p);
        load      = 1'b1;
        digits_in = d;
        dp_in     = p;
        @(negedge clk);
        load      = 1'b0;
    endtask

    // Returns at the negedge where frame_done is high.
    task automatic wait_fd();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (frame_done) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL frame_done_timeout got=none exp=pulse within 100 cycles");
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    logic [ND-1:0] prev_sel = '0;
    int cyc     = 0;
    int last_fd = -1;
    slot_exp_t m_e;

    always @(negedge clk) begin
        cyc++;
        if (!gap_chk) last_fd = -1;
        if ((digit_sel != prev_sel) && (digit_sel != '0)) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL slot_unexpected got sel=%b seg=%h dp=%b exp=no slot", digit_sel, seg_out, dp_out);
            end else begin
                m_e = exp_q.pop_front();
                if (digit_sel !== m_e.sel || seg_out !== m_e.seg || dp_out !== m_e.dp) begin
                    failures++;
                    $display("FAIL slot got sel=%b seg=%h dp=%b exp sel=%b seg=%h dp=%b (cycle %0d)",
                             digit_sel, seg_out, dp_out, m_e.sel, m_e.seg, m_e.dp, cyc);
                end
            end
        end
        prev_sel = digit_sel;
        if (frame_done) begin
            checks++;
            if (digit_sel !== 4'b1000) begin
                failures++;
                $display("FAIL fd_sel got=%b exp=1000", digit_sel);
            end
            if (gap_chk && last_fd >= 0) begin
                checks++;
                if (cyc - last_fd != ND * DIV) begin
                    failures++;
                    $display("FAIL fd_period got=%0d exp=%0d", cyc - last_fd, ND * DIV);
                end
            end
            last_fd = cyc;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        reset = 1'b1; enable = 1'b0; load = 1'b0; digits_in = '0; dp_in = '0;
        hex_mode = 1'b1; blank_lz = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_sel", 32'(digit_sel), 0);
        chk("rst_seg", 32'(seg_out), 0);
        chk("rst_dp",  32'(dp_out), 0);
        chk("rst_fd",  32'(frame_done), 0);

        push_frame(7'h3F, 7'h3F, 7'h3F, 7'h3F, 4'b0000);   // frame 1: reset zeros
        push_frame(7'h66, 7'h4F, 7'h5B, 7'h06, 4'b0000);   // frame 2: 1234
        reset = 1'b0;
        @(negedge clk);
        enable = 1'b1; gap_chk = 1'b1;

        repeat (5) @(negedge clk);
        do_load(16'h1234, 4'b0000);                         // mid-frame: held off
        wait_fd();                                          // end of frame 1

        hex_mode = 1'b0;
        push_frame(7'h40, 7'h3F, 7'h3F, 7'h3F, 4'b0001);   // frame 3: BCD B -> dash
        repeat (3) @(negedge clk);
        do_load(16'h000B, 4'b0001);
        wait_fd();                                          // end of frame 2

        push_frame(7'h7C, 7'h3F, 7'h3F, 7'h3F, 4'b0001);   // frame 4: hex b
        wait_fd();                                          // end of frame 3
        hex_mode = 1'b1;

        push_frame(7'h3F, 7'h6D, 7'h00, 7'h00, 4'b0000);   // frame 5: 0050 blanked
        repeat (3) @(negedge clk);
        do_load(16'h0050, 4'b0000);
        wait_fd();                                          // end of frame 4
        blank_lz = 1'b1;

        push_frame(7'h3F, 7'h00, 7'h00, 7'h00, 4'b1000);   // frame 6: 0000, dp on blank
        repeat (3) @(negedge clk);
        do_load(16'h0000, 4'b1000);
        wait_fd();                                          // end of frame 5

        push_frame(7'h71, 7'h77, 7'h6F, 7'h7F, 4'b0101);   // frame 7: 89AF
        push_slot(0, 7'h5E, 1'b0);                          // frame 8: 0C0D, paused in digit 1
        push_slot(1, 7'h3F, 1'b1);
        push_slot(1, 7'h3F, 1'b1);
        push_slot(2, 7'h39, 1'b0);
        push_slot(3, 7'h00, 1'b0);
        push_frame(7'h06, 7'h5B, 7'h4F, 7'h66, 4'b0000);   // frame 9: 4321

        // Load held across the boundary edge, then a second load right after.
        repeat (15) @(negedge clk);
        load = 1'b1; digits_in = 16'h89AF; dp_in = 4'b0101;
        @(negedge clk);
        digits_in = 16'h0C0D; dp_in = 4'b0010;
        @(negedge clk);
        load = 1'b0;
        wait_fd();                                          // end of frame 7

        repeat (6) @(negedge clk);
        enable = 1'b0; gap_chk = 1'b0;
        @(negedge clk);
        chk("dis_sel", 32'(digit_sel), 0);
        chk("dis_seg", 32'(seg_out), 0);
        chk("dis_dp",  32'(dp_out), 0);
        do_load(16'h4321, 4'b0000);                         // accepted while disabled
        repeat (4) @(negedge clk);
        chk("dis_hold_sel", 32'(digit_sel), 0);
        chk("dis_fd", 32'(frame_done), 0);
        enable = 1'b1;
        wait_fd();                                          // end of frame 8

        repeat (2) @(negedge clk);
        do_load(16'h5555, 4'b1111);                         // left pending
        repeat (3) @(negedge clk);
        chk("slots_before_reset", 32'(exp_q.size()), 2);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_sel", 32'(digit_sel), 0);
        chk("mid_rst_seg", 32'(seg_out), 0);
        chk("mid_rst_dp",  32'(dp_out), 0);
        chk("mid_rst_fd",  32'(frame_done), 0);
        exp_q.delete();
        push_frame(7'h3F, 7'h00, 7'h00, 7'h00, 4'b0000);
        push_frame(7'h3F, 7'h00, 7'h00, 7'h00, 4'b0000);   // pending 5555 must not appear
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0; gap_chk = 1'b1;
        wait_fd();
        wait_fd();
        chk("leftover_slots", 32'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #20000;
        failures++;
        $display("FAIL global_timeout got=running exp=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
